// File: rtl/bitstream_pkg.sv
// Shared definitions for the stochastic-to-binary bitstream counter.
package bitstream_pkg;

    // Converter FSM states, 2-bit encoded.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage : bitstream_pkg

// File: rtl/bitstream_counter.sv
// Stochastic-to-binary converter: after a start request it discards SKIP
// warm-up bits, counts the ones in the next 2^WIDTH bits and publishes the
// count with a valid/ack handshake. The count is the decoded probability
// scaled by 2^WIDTH.
module bitstream_counter #(
    parameter int WIDTH = 8,
    parameter int SKIP  = 8
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           x,
    input  logic           start,
    input  logic           ack,
    output logic           busy,
    output logic           valid,
    output logic [WIDTH:0] result
);

    import bitstream_pkg::*;

    // Skip counter needs to reach SKIP-1; keep at least one bit so SKIP=0 still elaborates.
    localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam logic [SKW-1:0]   SKIP_LAST   = SKW'((SKIP > 0) ? (SKIP - 1) : 0);
    // WIDTH-bit sample counter with terminal-count detect gives exactly 2^WIDTH samples.
    localparam logic [WIDTH-1:0] SAMPLE_LAST = '1;

    state_e           state_q;
    logic [WIDTH-1:0] sample_q;
    logic [SKW-1:0]   skip_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH:0]   acc_d;
    logic [WIDTH:0]   result_q;

    // Accumulator next value including the current bit; only consumed in COUNT,
    // so an unknown x elsewhere never reaches state.
    always_comb begin
        acc_d = acc_q + (WIDTH+1)'(x);
    end

    // Converter FSM with its counters, accumulator and result register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            sample_q <= '0;
            skip_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q    <= '0;
                        sample_q <= '0;
                        skip_q   <= '0;
                        state_q  <= (SKIP > 0) ? ST_SKIP : ST_COUNT;
                    end
                end
                ST_SKIP: begin
                    skip_q <= skip_q + SKW'(1);
                    if (skip_q == SKIP_LAST) begin
                        state_q <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    acc_q    <= acc_d;
                    sample_q <= sample_q + WIDTH'(1);
                    if (sample_q == SAMPLE_LAST) begin
                        // Publish the window total including this final sample.
                        result_q <= acc_d;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Status flags decode from the registered state only.
    always_comb begin
        busy  = (state_q == ST_SKIP) || (state_q == ST_COUNT);
        valid = (state_q == ST_DONE);
    end

    assign result = result_q;

endmodule : bitstream_counter

// File: tb/tb_bitstream_counter.sv
// Directed + randomized bench for bitstream_counter. Expected counts come from
// a window model: sum of the bits presented at edges SKIP+1 .. SKIP+2^WIDTH
// after the start edge.
module tb_bitstream_counter;

    localparam int W = 4;
    localparam int S = 2;
    localparam int N = 1 << W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;

    // Main instance: WIDTH=4, SKIP=2
    logic       x_a, start_a, ack_a, busy_a, valid_a;
    logic [W:0] result_a;
    // SKIP=0 variant
    logic       x_b, start_b, ack_b, busy_b, valid_b;
    logic [W:0] result_b;
    // WIDTH=8, SKIP=8 variant
    logic       x_c, start_c, ack_c, busy_c, valid_c;
    logic [8:0] result_c;

    bitstream_counter #(.WIDTH(W), .SKIP(S)) dut_a (
        .clk(clk), .n_rst(n_rst), .x(x_a), .start(start_a), .ack(ack_a),
        .busy(busy_a), .valid(valid_a), .result(result_a)
    );

    bitstream_counter #(.WIDTH(W), .SKIP(0)) dut_b (
        .clk(clk), .n_rst(n_rst), .x(x_b), .start(start_b), .ack(ack_b),
        .busy(busy_b), .valid(valid_b), .result(result_b)
    );

    bitstream_counter #(.WIDTH(8), .SKIP(8)) dut_c (
        .clk(clk), .n_rst(n_rst), .x(x_c), .start(start_c), .ack(ack_c),
        .busy(busy_c), .valid(valid_c), .result(result_c)
    );

    int tests  = 0;
    int failed = 0;
    int last_exp = 0;
    logic xs [0:S+N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Run one window on the main instance. mode selects the bit pattern:
    // 0 all ones, 1 all zeros, 2 ones only in skip, 3 one on first sample,
    // 4 one on last sample, 5 alternating 1,0 (skip bits X), 6 random (skip bits X).
    task automatic run_window(input int mode, input string tag, input bit poke);
        int total;
        int c;
        int exp;
        total = S + N;
        exp = 0;
        for (int k = 1; k <= total; k++) begin
            c = k - S;
            case (mode)
                0: xs[k] = 1'b1;
                1: xs[k] = 1'b0;
                2: xs[k] = (c < 1) ? 1'b1 : 1'b0;
                3: xs[k] = (c == 1) ? 1'b1 : 1'b0;
                4: xs[k] = (c == N) ? 1'b1 : 1'b0;
                5: xs[k] = (c < 1) ? 1'bx : ((c % 2) == 1);
                default: xs[k] = (c < 1) ? 1'bx : 1'($urandom_range(0, 1));
            endcase
        end
        for (int k = S + 1; k <= total; k++) begin
            if (xs[k] === 1'b1) exp++;
        end
        last_exp = exp;

        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        x_a = xs[1];
        check({tag, " busy_after_start"}, 32'(busy_a), 32'd1);
        for (int k = 1; k <= total; k++) begin
            @(posedge clk); #1;
            if (k < total) begin
                check({tag, " busy_in_window"}, 32'(busy_a), 32'd1);
                check({tag, " valid_in_window"}, 32'(valid_a), 32'd0);
                x_a = xs[k+1];
                start_a = (poke && k == S + 3);
                ack_a   = (poke && k == S + 5);
            end else begin
                x_a = 1'bx;
                check({tag, " valid_at_end"}, 32'(valid_a), 32'd1);
                check({tag, " busy_at_end"}, 32'(busy_a), 32'd0);
                check({tag, " result"}, 32'(result_a), 32'(exp));
            end
        end
        $display("[TB] window %s: expected %0d, got %0d", tag, exp, result_a);
    endtask

    // Leave DONE: optional 5-cycle hold with ack low, then ack (optionally with start).
    task automatic finish_done(input string tag, input bit hold, input bit with_start);
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                check({tag, " hold_valid"}, 32'(valid_a), 32'd1);
                check({tag, " hold_result"}, 32'(result_a), 32'(last_exp));
            end
        end
        ack_a = 1'b1;
        start_a = with_start;
        @(posedge clk); #1;
        ack_a = 1'b0;
        start_a = 1'b0;
        check({tag, " ack_valid"}, 32'(valid_a), 32'd0);
        check({tag, " ack_result_kept"}, 32'(result_a), 32'(last_exp));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check({tag, " idle_no_window"}, 32'(busy_a), 32'd0);
        end
    endtask

    initial begin
        n_rst = 1'b1;
        x_a = 1'b0; start_a = 1'b0; ack_a = 1'b0;
        x_b = 1'b1; start_b = 1'b0; ack_b = 1'b0;
        x_c = 1'b1; start_c = 1'b0; ack_c = 1'b0;
        #1 n_rst = 1'b0;
        #11;
        check("reset busy_a", 32'(busy_a), 32'd0);
        check("reset valid_a", 32'(valid_a), 32'd0);
        check("reset result_a", 32'(result_a), 32'd0);
        check("reset valid_b", 32'(valid_b), 32'd0);
        check("reset result_c", 32'(result_c), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // All ones with a held DONE, then all zeros and ones again.
        run_window(0, "ones", 1'b0);
        finish_done("ones", 1'b1, 1'b0);
        run_window(1, "zeros", 1'b0);
        finish_done("zeros", 1'b0, 1'b0);
        run_window(0, "ones_again", 1'b0);
        finish_done("ones_again", 1'b0, 1'b0);

        // Window edges: skip discard, first and last sample.
        run_window(2, "skip_only", 1'b0);
        finish_done("skip_only", 1'b0, 1'b0);
        run_window(3, "first_sample", 1'b0);
        finish_done("first_sample", 1'b0, 1'b0);
        run_window(4, "last_sample", 1'b0);
        finish_done("last_sample", 1'b0, 1'b0);

        // Alternating with stray start/ack mid-window, then start+ack in DONE.
        run_window(5, "alternate", 1'b1);
        finish_done("alternate", 1'b0, 1'b1);

        // Random windows.
        for (int r = 0; r < 4; r++) begin
            run_window(6, "random", 1'b0);
            finish_done("random", 1'b0, 1'b0);
        end

        // Reset mid-COUNT after 7 ones; previous result is nonzero.
        run_window(0, "pre_reset", 1'b0);
        finish_done("pre_reset", 1'b0, 1'b0);
        start_a = 1'b1;
        x_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (S + 7) @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        check("midreset busy", 32'(busy_a), 32'd0);
        check("midreset valid", 32'(valid_a), 32'd0);
        check("midreset result", 32'(result_a), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        run_window(0, "after_reset", 1'b0);
        finish_done("after_reset", 1'b0, 1'b0);

        // SKIP=0 variant: valid after edge 16.
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int k = 1; k <= N; k++) begin
            @(posedge clk); #1;
            if (k < N) begin
                check("skip0 valid_in_window", 32'(valid_b), 32'd0);
                check("skip0 busy_in_window", 32'(busy_b), 32'd1);
            end else begin
                check("skip0 valid_at_end", 32'(valid_b), 32'd1);
                check("skip0 result", 32'(result_b), 32'd16);
            end
        end
        $display("[TB] window skip0: expected 16, got %0d", result_b);
        ack_b = 1'b1;
        @(posedge clk); #1;
        ack_b = 1'b0;
        check("skip0 ack_valid", 32'(valid_b), 32'd0);

        // WIDTH=8, SKIP=8 with constant-one input: full-scale 256.
        start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        for (int k = 1; k <= 8 + 256; k++) begin
            @(posedge clk); #1;
            if (k == 8 + 255) check("w8 valid_before_end", 32'(valid_c), 32'd0);
        end
        check("w8 valid_at_end", 32'(valid_c), 32'd1);
        check("w8 result", 32'(result_c), 32'd256);
        $display("[TB] window w8: expected 256, got %0d", result_c);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_bitstream_counter
